// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo controller: opcodes,
// FSM state encoding, fault codes and instruction-word field layout.
// Instruction word, MSB to LSB: {op[1:0], chan[CH_W-1:0], chain, pos[POS_W-1:0]}.
package servo_pkg;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_EXT  = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_CHAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_BAD_CH  = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // Channel field width; a single-channel build still carries one bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int instr_w(input int num_ch, input int pos_w);
    return 2 + ch_w(num_ch) + 1 + pos_w;
  endfunction

  function automatic int chain_lsb(input int pos_w);
    return pos_w;
  endfunction

  function automatic int chan_lsb(input int pos_w);
    return pos_w + 1;
  endfunction

  function automatic int op_lsb(input int num_ch, input int pos_w);
    return pos_w + 1 + ch_w(num_ch);
  endfunction

endpackage

// File: rtl/servo_multi_ctrl_if.sv
// Instruction channel into the servo controller.
// Handshake: the producer holds instr_valid and instr_data stable until a
// cycle in which instr_ready is also high; that clock edge is the transfer.
interface servo_multi_ctrl_if #(
  parameter int DATA_W = 13
) ();
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;

  modport master (output instr_valid, output instr_data, input instr_ready);
  modport slave  (input instr_valid, input instr_data, output instr_ready);
endinterface

// File: rtl/servo_pwm_ch.sv
// Single-channel servo PWM generator. The position is latched at the start
// of each frame so a command change never produces a truncated pulse.
// Optional build macro SERVO_SOFT_RAMP_EN: the applied position slews one
// LSB per RAMP_CYC cycles toward the commanded position.
module servo_pwm_ch #(
  parameter int POS_W         = 8,
  parameter int PERIOD_CYC    = 720000,
  parameter int MIN_PULSE_CYC = 24000,
  parameter int STEP_CYC      = 94,
  parameter int RAMP_CYC      = 24000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [POS_W-1:0] pos,
  output logic             pulse
);

  localparam int CNT_W = $clog2(PERIOD_CYC);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] thr;
  logic [POS_W-1:0] pos_app;
  logic [POS_W-1:0] pos_lat;
  logic [POS_W-1:0] pos_eff;

  if (RAMP_CYC < 1) begin : g_bad_ramp
    $error("servo_pwm_ch: RAMP_CYC must be at least 1");
  end

`ifdef SERVO_SOFT_RAMP_EN
  localparam int RW = (RAMP_CYC > 2) ? $clog2(RAMP_CYC) : 1;
  logic [RW-1:0] ramp_cnt;

  // Slew the applied position one LSB toward the command every RAMP_CYC cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_cnt <= '0;
      pos_app  <= '0;
    end else if (ramp_cnt == RW'(RAMP_CYC - 1)) begin
      ramp_cnt <= '0;
      if (pos_app < pos)      pos_app <= pos_app + POS_W'(1);
      else if (pos_app > pos) pos_app <= pos_app - POS_W'(1);
    end else begin
      ramp_cnt <= ramp_cnt + RW'(1);
    end
  end
`else
  assign pos_app = pos;
`endif

  // At count 0 the live value is used, so the first frame after enable
  // already reflects the position written in the same cycle.
  assign pos_eff = (cnt == '0) ? pos_app : pos_lat;
  assign thr     = CNT_W'(MIN_PULSE_CYC) + CNT_W'(pos_eff) * CNT_W'(STEP_CYC);
  assign pulse   = en && (cnt < thr);

  // Frame counter; held at 0 while disabled so enable starts a fresh frame.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(PERIOD_CYC - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame-start position latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_lat <= '0;
    end else if (cnt == '0) begin
      pos_lat <= pos_app;
    end
  end

endmodule

// File: rtl/servo_multi_ctrl.sv
// Multi-channel servo controller: decodes STOP/SET/EXTEND/RETRACT words,
// runs limit-switch-terminated moves with a timeout, and drives one PWM
// generator per channel. Optional build macro SERVO_SOFT_RAMP_EN enables
// position slewing inside each PWM channel.
module servo_multi_ctrl
  import servo_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int POS_W         = 8,
  parameter int PERIOD_CYC    = 720000,
  parameter int MIN_PULSE_CYC = 24000,
  parameter int STEP_CYC      = 94,
  parameter int TIMEOUT_CYC   = 48000000,
  parameter int RAMP_CYC      = 24000
) (
  input  logic                clk,
  input  logic                reset,
  servo_multi_ctrl_if.slave   instr,
  input  logic [NUM_CH-1:0]   limit_ext_n,
  input  logic [NUM_CH-1:0]   limit_ret_n,
  output logic [NUM_CH-1:0]   servo_pulse,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic [1:0]          state_dbg
);

  localparam int CH_W     = ch_w(NUM_CH);
  localparam int CHAIN_B  = chain_lsb(POS_W);
  localparam int CHAN_LSB = chan_lsb(POS_W);
  localparam int OP_LSB   = op_lsb(NUM_CH, POS_W);
  localparam int TO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int CH_SPAN  = 1 << CH_W;
  // Bit i set when channel number i exists.
  localparam logic [CH_SPAN-1:0] CH_OK = {CH_SPAN{1'b1}} >> (CH_SPAN - NUM_CH);
  localparam longint MAX_PULSE = longint'(MIN_PULSE_CYC)
                               + ((longint'(1) << POS_W) - 1) * longint'(STEP_CYC);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("servo_multi_ctrl: NUM_CH must be 1..16");
  end
  if (MAX_PULSE >= longint'(PERIOD_CYC)) begin : g_bad_pulse
    $error("servo_multi_ctrl: longest pulse does not fit in the PWM frame");
  end

  state_t            state;
  logic [NUM_CH-1:0] en;
  logic [POS_W-1:0]  pos_q [NUM_CH];
  logic [CH_W-1:0]   chan_r;
  logic              chain_r;
  logic              dir_ext;
  logic [TO_W-1:0]   to_cnt;
  logic [NUM_CH-1:0] ext_s1, ext_s2, ret_s1, ret_s2;

  logic [1:0]        in_op;
  logic [CH_W-1:0]   in_chan;
  logic              in_chain;
  logic [POS_W-1:0]  in_pos;
  logic              accept;
  logic              lim_hit;

  assign in_pos   = instr.instr_data[POS_W-1:0];
  assign in_chain = instr.instr_data[CHAIN_B];
  assign in_chan  = instr.instr_data[CHAN_LSB +: CH_W];
  assign in_op    = instr.instr_data[OP_LSB +: 2];

  assign instr.instr_ready = (state == ST_IDLE) && !reset;
  assign accept            = instr.instr_valid && instr.instr_ready;
  assign lim_hit           = dir_ext ? !ext_s2[chan_r] : !ret_s2[chan_r];

  assign busy      = (state == ST_MOVE) || (state == ST_CHAIN);
  assign done      = (state == ST_FIN);
  assign state_dbg = state;

  // Two-flop synchronisers for the asynchronous limit switches (idle high).
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_s1 <= '1;
      ext_s2 <= '1;
      ret_s1 <= '1;
      ret_s2 <= '1;
    end else begin
      ext_s1 <= limit_ext_n;
      ext_s2 <= ext_s1;
      ret_s1 <= limit_ret_n;
      ret_s2 <= ret_s1;
    end
  end

  // Instruction sequencer: owns channel enables, positions and fault state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      en         <= '0;
      for (int i = 0; i < NUM_CH; i++) pos_q[i] <= '0;
      chan_r     <= '0;
      chain_r    <= 1'b0;
      dir_ext    <= 1'b0;
      to_cnt     <= '0;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
            chan_r     <= in_chan;
            chain_r    <= in_chain;
            to_cnt     <= '0;
            if (!CH_OK[in_chan]) begin
              fault      <= 1'b1;
              fault_code <= FAULT_BAD_CH;
              state      <= ST_FIN;
            end else begin
              case (in_op)
                OP_STOP: begin
                  en    <= '0;
                  state <= ST_FIN;
                end
                OP_SET: begin
                  pos_q[in_chan] <= in_pos;
                  en[in_chan]    <= 1'b1;
                  state          <= ST_FIN;
                end
                OP_EXT: begin
                  dir_ext <= 1'b1;
                  state   <= ST_MOVE;
                end
                default: begin
                  dir_ext <= 1'b0;
                  state   <= ST_MOVE;
                end
              endcase
            end
          end
        end
        ST_MOVE: begin
          if (lim_hit) begin
            en[chan_r] <= 1'b0;
            state      <= (dir_ext && chain_r) ? ST_CHAIN : ST_FIN;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            en[chan_r] <= 1'b0;
            fault      <= 1'b1;
            fault_code <= FAULT_TIMEOUT;
            state      <= ST_FIN;
          end else begin
            en[chan_r]    <= 1'b1;
            pos_q[chan_r] <= {POS_W{dir_ext}};
            to_cnt        <= to_cnt + TO_W'(1);
          end
        end
        ST_CHAIN: begin
          dir_ext <= 1'b0;
          to_cnt  <= '0;
          state   <= ST_MOVE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    servo_pwm_ch #(
      .POS_W         (POS_W),
      .PERIOD_CYC    (PERIOD_CYC),
      .MIN_PULSE_CYC (MIN_PULSE_CYC),
      .STEP_CYC      (STEP_CYC),
      .RAMP_CYC      (RAMP_CYC)
    ) u_pwm (
      .clk   (clk),
      .reset (reset),
      .en    (en[g]),
      .pos   (pos_q[g]),
      .pulse (servo_pulse[g])
    );
  end

endmodule

// File: tb/tb_servo_multi_ctrl.sv
// Directed bench for servo_multi_ctrl: a 4-channel instance for the main
// flows and a 3-channel instance for the out-of-range channel case.
module tb_servo_multi_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  servo_multi_ctrl_if #(.DATA_W(13)) bus_a ();
  servo_multi_ctrl_if #(.DATA_W(13)) bus_b ();

  logic [3:0] ext_a, ret_a, pulse_a;
  logic       busy_a, done_a, fault_a;
  logic [1:0] code_a, st_a;
  logic [2:0] ext_b, ret_b, pulse_b;
  logic       busy_b, done_b, fault_b;
  logic [1:0] code_b, st_b;

  servo_multi_ctrl #(
    .NUM_CH(4), .POS_W(8), .PERIOD_CYC(1000), .MIN_PULSE_CYC(100),
    .STEP_CYC(2), .TIMEOUT_CYC(500)
  ) dut_a (
    .clk(clk), .reset(reset), .instr(bus_a.slave),
    .limit_ext_n(ext_a), .limit_ret_n(ret_a), .servo_pulse(pulse_a),
    .busy(busy_a), .done(done_a), .fault(fault_a), .fault_code(code_a),
    .state_dbg(st_a)
  );

  servo_multi_ctrl #(
    .NUM_CH(3), .POS_W(8), .PERIOD_CYC(1000), .MIN_PULSE_CYC(100),
    .STEP_CYC(2), .TIMEOUT_CYC(500)
  ) dut_b (
    .clk(clk), .reset(reset), .instr(bus_b.slave),
    .limit_ext_n(ext_b), .limit_ret_n(ret_b), .servo_pulse(pulse_b),
    .busy(busy_b), .done(done_b), .fault(fault_b), .fault_code(code_b),
    .state_dbg(st_b)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt_a = 0;
  int d0;
  int hi [4];
  int hb [3];
  int busy_n;

  // Count done pulses on the main instance.
  always @(posedge clk) if (done_a === 1'b1) done_cnt_a++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one word at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input bit sel, input logic [1:0] op, input logic [1:0] chan,
                      input logic chain, input logic [7:0] pos);
    int t;
    logic rdy;
    t = 0;
    rdy = sel ? bus_b.instr_ready : bus_a.instr_ready;
    while (rdy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
      rdy = sel ? bus_b.instr_ready : bus_a.instr_ready;
    end
    if (t >= 20) check("ready_wait", 32'(rdy), 32'd1);
    if (sel) begin
      bus_b.instr_data  = {op, chan, chain, pos};
      bus_b.instr_valid = 1'b1;
    end else begin
      bus_a.instr_data  = {op, chan, chain, pos};
      bus_a.instr_valid = 1'b1;
    end
    @(negedge clk);
    bus_a.instr_valid = 1'b0;
    bus_b.instr_valid = 1'b0;
  endtask

  // Sample n consecutive falling edges, counting high cycles per output.
  task automatic measure(input int n);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int c = 0; c < 3; c++) hb[c] = 0;
    busy_n = 0;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 4; c++) hi[c] += int'(pulse_a[c]);
      for (int c = 0; c < 3; c++) hb[c] += int'(pulse_b[c]);
      busy_n += int'(busy_a);
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_a.instr_valid = 1'b0; bus_a.instr_data = '0;
    bus_b.instr_valid = 1'b0; bus_b.instr_data = '0;
    ext_a = '1; ret_a = '1; ext_b = '1; ret_b = '1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ready", 32'(bus_a.instr_ready), 1);
    check("rst_pulse", 32'(pulse_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_fault", 32'(fault_a), 0);
    check("rst_code", 32'(code_a), 0);
    check("rst_state", 32'(st_a), 0);

    // SET ch2 pos 50: 100 + 50*2 = 200 high per frame
    d0 = done_cnt_a;
    send(0, 2'b01, 2'd2, 1'b0, 8'd50);
    check("set_done", 32'(done_a), 1);
    check("set_state", 32'(st_a), 3);
    ticks(1);
    check("set_done_once", 32'(done_cnt_a - d0), 1);
    check("set_done_low", 32'(done_a), 0);
    measure(1000);
    check("set_ch2_hi", 32'(hi[2]), 200);
    check("set_others_hi", 32'(hi[0] + hi[1] + hi[3]), 0);

    // EXTEND ch1, ext limit after 300 cycles
    send(0, 2'b10, 2'd1, 1'b0, 8'd0);
    measure(300);
    check("ext_hi", 32'(hi[1]), 299);
    check("ext_busy", 32'(busy_n), 300);
    ext_a[1] = 1'b0;
    ticks(2);
    check("ext_busy_hold", 32'(busy_a), 1);
    ticks(1);
    check("ext_pulse_off", 32'(pulse_a[1]), 0);
    check("ext_done", 32'(done_a), 1);
    check("ext_fault", 32'(fault_a), 0);
    ext_a[1] = 1'b1;
    ticks(2);

    // SET ch1 full scale: 100 + 255*2 = 610
    send(0, 2'b01, 2'd1, 1'b0, 8'd255);
    measure(1000);
    check("set_max_hi", 32'(hi[1]), 610);
    check("set_ch2_keep", 32'(hi[2]), 200);

    // STOP clears every channel
    send(0, 2'b00, 2'd0, 1'b0, 8'd0);
    check("stop_done", 32'(done_a), 1);
    measure(1000);
    check("stop_hi", 32'(hi[0] + hi[1] + hi[2] + hi[3]), 0);

    // EXTEND ch0 with chain: ext limit at 100, ret limit at 200
    d0 = done_cnt_a;
    send(0, 2'b10, 2'd0, 1'b1, 8'd0);
    measure(100);
    check("chain_ext_hi", 32'(hi[0]), 99);
    check("chain_busy1", 32'(busy_n), 100);
    ext_a[0] = 1'b0;
    measure(100);
    check("chain_mid_hi", 32'(hi[0]), 98);
    check("chain_busy2", 32'(busy_n), 100);
    check("chain_state", 32'(st_a), 1);
    ret_a[0] = 1'b0;
    ticks(2);
    check("chain_busy3", 32'(busy_a), 1);
    ticks(1);
    check("chain_done", 32'(done_a), 1);
    check("chain_pulse_off", 32'(pulse_a[0]), 0);
    ext_a[0] = 1'b1;
    ret_a[0] = 1'b1;
    ticks(3);
    check("chain_done_once", 32'(done_cnt_a - d0), 1);

    // RETRACT ch3 with no limit: timeout after 500 cycles, pos 0 = 100 high
    send(0, 2'b11, 2'd3, 1'b0, 8'd0);
    measure(500);
    check("to_hi", 32'(hi[3]), 100);
    check("to_busy", 32'(busy_n), 500);
    check("to_fault", 32'(fault_a), 1);
    check("to_code", 32'(code_a), 2);
    check("to_done", 32'(done_a), 1);
    check("to_pulse_off", 32'(pulse_a[3]), 0);
    ticks(1);
    check("to_ready", 32'(bus_a.instr_ready), 1);
    check("to_sticky", 32'(fault_a), 1);
    check("to_idle", 32'(st_a), 0);

    // Next instruction clears the fault; SET ch0 pos 0 = minimum pulse
    send(0, 2'b01, 2'd0, 1'b0, 8'd0);
    check("clr_fault", 32'(fault_a), 0);
    check("clr_code", 32'(code_a), 0);
    measure(1000);
    check("min_hi", 32'(hi[0]), 100);

    // Three-channel instance: channel 3 does not exist
    send(1, 2'b01, 2'd1, 1'b0, 8'd0);
    send(1, 2'b01, 2'd3, 1'b0, 8'd77);
    check("bad_done", 32'(done_b), 1);
    check("bad_fault", 32'(fault_b), 1);
    check("bad_code", 32'(code_b), 1);
    measure(1000);
    check("bad_ch1_hi", 32'(hb[1]), 100);
    check("bad_other_hi", 32'(hb[0] + hb[2]), 0);
    send(1, 2'b01, 2'd0, 1'b0, 8'd0);
    check("bad_clr_fault", 32'(fault_b), 0);
    check("bad_clr_code", 32'(code_b), 0);

    // Reset in the middle of a move while pulses are high
    send(0, 2'b10, 2'd1, 1'b0, 8'd0);
    measure(50);
    check("rm_pulse_before", 32'(pulse_a[1]), 1);
    check("rm_busy_before", 32'(busy_a), 1);
    reset = 1'b1;
    @(negedge clk);
    check("rm_pulse", 32'(pulse_a), 0);
    check("rm_state", 32'(st_a), 0);
    check("rm_busy", 32'(busy_a), 0);
    check("rm_ready_in_reset", 32'(bus_a.instr_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rm_ready", 32'(bus_a.instr_ready), 1);
    check("rm_pulse_after", 32'(pulse_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
